// File: rtl/sc_crashctrl_pkg.sv
// Shared definitions for the crash/round controller and the top level that
// wires the point/background registers.
//   state_t            : FSM state encoding (3 bits)
//   SC_*_DEF           : default parameter values
package sc_crashctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_BLINK    = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  localparam int unsigned SC_LIVES_INIT_DEF   = 3;
  localparam int unsigned SC_LIVES_W_DEF      = 3;
  localparam int unsigned SC_BLINK_TICKS_DEF  = 4;
  localparam int unsigned SC_BLINK_CYCLES_DEF = 3;

endpackage

// File: rtl/sc_crashctrl_blinktimer.sv
// sc_blinktimer: tick counter plus phase counter used to pace the crash blink.
//   i_clk        system clock
//   i_rst_n      synchronous active-low reset
//   i_clear      restart at tick 0 / phase 0 (wins over i_enable)
//   i_enable     count one tick
//   o_phase_lsb  LSB of the current phase (0 = even phase)
//   o_done       one-cycle flag after the last tick of the last phase
module sc_blinktimer #(
  parameter int unsigned BLINK_TICKS  = sc_crashctrl_pkg::SC_BLINK_TICKS_DEF,
  parameter int unsigned BLINK_CYCLES = sc_crashctrl_pkg::SC_BLINK_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_phase_lsb,
  output logic o_done
);

  localparam int unsigned TK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned PH_W = $clog2(2 * BLINK_CYCLES);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(BLINK_TICKS - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * BLINK_CYCLES - 1);

  logic [TK_W-1:0] r_tick_cnt;
  logic [PH_W-1:0] r_phase;
  logic            r_done;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_tick_cnt <= '0;
      r_phase    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_enable) begin
        if (r_tick_cnt == TK_LAST) begin
          r_tick_cnt <= '0;
          // Phase holds at the last (odd) value on completion so the display
          // stays shown during the single exit cycle.
          if (r_phase == PH_LAST) begin
            r_done <= 1'b1;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end else begin
          r_tick_cnt <= r_tick_cnt + TK_W'(1);
        end
      end
    end
  end

  assign o_phase_lsb = r_phase[0];
  assign o_done      = r_done;

endmodule

// File: rtl/sc_crashctrl.sv
// sc_crashctrl: game-round controller downstream of the crash detector.
// Sequences clear/load/run of the point and background registers, freezes
// play and blinks the display on a collision, counts lives and enters game
// over when they run out.
//   SC_CRASHCTRL_CLOCK_50      system clock
//   SC_CRASHCTRL_RESET_InLow   synchronous active-low reset
//   SC_CRASHCTRL_Crash_InLow   collision flag, 0 = collision (used in RUN only)
//   SC_CRASHCTRL_Start_InLow   start button, 0 = pressed (falling edge = event)
//   SC_CRASHCTRL_Tick_In       game-step pulse (used in BLINK only)
//   SC_CRASHCTRL_Clear_Out     one-cycle clear of point/background registers
//   SC_CRASHCTRL_Load_Out      one-cycle load of initial patterns
//   SC_CRASHCTRL_Run_Out       shift enable
//   SC_CRASHCTRL_Blank_Out     display blank request
//   SC_CRASHCTRL_GameOver_Out  game-over indicator
//   SC_CRASHCTRL_Lives_Out     remaining lives
module sc_crashctrl
  import sc_crashctrl_pkg::*;
#(
  parameter int unsigned LIVES_INIT   = SC_LIVES_INIT_DEF,
  parameter int unsigned LIVES_W      = SC_LIVES_W_DEF,
  parameter int unsigned BLINK_TICKS  = SC_BLINK_TICKS_DEF,
  parameter int unsigned BLINK_CYCLES = SC_BLINK_CYCLES_DEF
) (
  input  logic               SC_CRASHCTRL_CLOCK_50,
  input  logic               SC_CRASHCTRL_RESET_InLow,
  input  logic               SC_CRASHCTRL_Crash_InLow,
  input  logic               SC_CRASHCTRL_Start_InLow,
  input  logic               SC_CRASHCTRL_Tick_In,
  output logic               SC_CRASHCTRL_Clear_Out,
  output logic               SC_CRASHCTRL_Load_Out,
  output logic               SC_CRASHCTRL_Run_Out,
  output logic               SC_CRASHCTRL_Blank_Out,
  output logic               SC_CRASHCTRL_GameOver_Out,
  output logic [LIVES_W-1:0] SC_CRASHCTRL_Lives_Out
);

  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_start_prev;
  logic [LIVES_W-1:0] r_lives;
  logic               r_clear;
  logic               r_load;
  logic               r_run;
  logic               r_in_blink;
  logic               r_gameover;

  logic w_start_evt;
  logic w_crash_hit;
  logic w_blink_en;
  logic w_phase_lsb;
  logic w_done;

  assign w_start_evt = r_start_prev & ~SC_CRASHCTRL_Start_InLow;
  assign w_crash_hit = (r_state == ST_RUN) & ~SC_CRASHCTRL_Crash_InLow;
  // Ticks arriving in the exit cycle are dropped; a crash-cycle tick is lost
  // because the timer clear wins over enable.
  assign w_blink_en  = (r_state == ST_BLINK) & SC_CRASHCTRL_Tick_In & ~w_done;

  sc_blinktimer #(
    .BLINK_TICKS  (BLINK_TICKS),
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_blinktimer (
    .i_clk       (SC_CRASHCTRL_CLOCK_50),
    .i_rst_n     (SC_CRASHCTRL_RESET_InLow),
    .i_clear     (w_crash_hit),
    .i_enable    (w_blink_en),
    .o_phase_lsb (w_phase_lsb),
    .o_done      (w_done)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_start_evt) w_state_nxt = ST_CLEAR;
      ST_CLEAR:    w_state_nxt = ST_LOAD;
      ST_LOAD:     w_state_nxt = ST_RUN;
      ST_RUN:      if (w_crash_hit) w_state_nxt = ST_BLINK;
      ST_BLINK:    if (w_done) w_state_nxt = (r_lives == '0) ? ST_GAMEOVER : ST_CLEAR;
      ST_GAMEOVER: if (w_start_evt) w_state_nxt = ST_CLEAR;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge SC_CRASHCTRL_CLOCK_50) begin
    if (!SC_CRASHCTRL_RESET_InLow) begin
      r_state      <= ST_IDLE;
      r_start_prev <= 1'b1;
      r_lives      <= LIVES_LOAD;
      r_clear      <= 1'b0;
      r_load       <= 1'b0;
      r_run        <= 1'b0;
      r_in_blink   <= 1'b0;
      r_gameover   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_prev <= SC_CRASHCTRL_Start_InLow;
      r_clear      <= (w_state_nxt == ST_CLEAR);
      r_load       <= (w_state_nxt == ST_LOAD);
      r_run        <= (w_state_nxt == ST_RUN);
      r_in_blink   <= (w_state_nxt == ST_BLINK);
      r_gameover   <= (w_state_nxt == ST_GAMEOVER);
      if (((r_state == ST_IDLE) || (r_state == ST_GAMEOVER)) && w_start_evt) begin
        r_lives <= LIVES_LOAD;
      end else if (w_crash_hit && (r_lives != '0)) begin
        r_lives <= r_lives - LIVES_W'(1);
      end
    end
  end

  assign SC_CRASHCTRL_Clear_Out    = r_clear;
  assign SC_CRASHCTRL_Load_Out     = r_load;
  assign SC_CRASHCTRL_Run_Out      = r_run;
  // Both terms are flops: in-blink flag and the timer's phase LSB change on
  // the same edge, so blank follows the phase without an extra cycle.
  assign SC_CRASHCTRL_Blank_Out    = r_in_blink & ~w_phase_lsb;
  assign SC_CRASHCTRL_GameOver_Out = r_gameover;
  assign SC_CRASHCTRL_Lives_Out    = r_lives;

endmodule

// File: tb/tb_sc_crashctrl.sv
// Directed bench for sc_crashctrl with LIVES_INIT=3, BLINK_TICKS=2,
// BLINK_CYCLES=2. Inputs are driven and outputs sampled on the falling edge.
module tb_sc_crashctrl;

  logic       clk;
  logic       rst_n;
  logic       crash_n;
  logic       start_n;
  logic       tick;
  logic       clear_o;
  logic       load_o;
  logic       run_o;
  logic       blank_o;
  logic       gameover_o;
  logic [2:0] lives_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Blank after the k-th tick of a blink (k = 1..8); the 8th tick leaves
  // the display shown for the single exit cycle.
  logic exp_blank [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  sc_crashctrl #(
    .LIVES_INIT   (3),
    .LIVES_W      (3),
    .BLINK_TICKS  (2),
    .BLINK_CYCLES (2)
  ) dut (
    .SC_CRASHCTRL_CLOCK_50     (clk),
    .SC_CRASHCTRL_RESET_InLow  (rst_n),
    .SC_CRASHCTRL_Crash_InLow  (crash_n),
    .SC_CRASHCTRL_Start_InLow  (start_n),
    .SC_CRASHCTRL_Tick_In      (tick),
    .SC_CRASHCTRL_Clear_Out    (clear_o),
    .SC_CRASHCTRL_Load_Out     (load_o),
    .SC_CRASHCTRL_Run_Out      (run_o),
    .SC_CRASHCTRL_Blank_Out    (blank_o),
    .SC_CRASHCTRL_GameOver_Out (gameover_o),
    .SC_CRASHCTRL_Lives_Out    (lives_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cyc(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  // Outputs packed as {clear, load, run, blank, gameover}.
  function automatic logic [4:0] outs();
    return {clear_o, load_o, run_o, blank_o, gameover_o};
  endfunction

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic crash_pulse();
    crash_n = 1'b0;
    cyc(1);
    crash_n = 1'b1;
  endtask

  // Start event, then check the Clear/Load/Run sequence and reloaded lives.
  task automatic start_round(input string tag);
    start_n = 1'b0;
    cyc(1);
    chk({tag, "_clear"}, 32'(outs()), 32'(5'b10000));
    chk({tag, "_lives"}, 32'(lives_o), 32'd3);
    cyc(1);
    chk({tag, "_load"}, 32'(outs()), 32'(5'b01000));
    start_n = 1'b1;
    cyc(1);
    chk({tag, "_run"}, 32'(outs()), 32'(5'b00100));
  endtask

  // Eight ticks of a blink with per-tick blank checks, then the exit cycle.
  task automatic full_blink(input string tag);
    for (int k = 0; k < 8; k++) begin
      do_tick();
      chk($sformatf("%s_blank%0d", tag, k + 1), 32'(blank_o), 32'(exp_blank[k]));
      if (k < 7) cyc(1);
    end
    chk({tag, "_exitwait"}, 32'(outs()), 32'(5'b00000));
  endtask

  initial begin
    int clr_cnt;
    rst_n   = 1'b0;
    crash_n = 1'b1;
    start_n = 1'b1;
    tick    = 1'b0;
    cyc(2);
    chk("rst_outs", 32'(outs()), 32'(5'b00000));
    chk("rst_lives", 32'(lives_o), 32'd3);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_outs", 32'(outs()), 32'(5'b00000));

    // 1: start sequence
    start_round("start1");

    // 4b: start pulse during RUN has no effect
    start_n = 1'b0;
    cyc(1);
    start_n = 1'b1;
    cyc(1);
    chk("run_start_ign", 32'(outs()), 32'(5'b00100));

    // 2: single crash
    crash_pulse();
    chk("crash1_outs", 32'(outs()), 32'(5'b00010));
    chk("crash1_lives", 32'(lives_o), 32'd2);
    // start pulse and crash during BLINK are ignored
    start_n = 1'b0;
    crash_n = 1'b0;
    cyc(1);
    start_n = 1'b1;
    crash_n = 1'b1;
    chk("blink_start_ign", 32'(outs()), 32'(5'b00010));
    chk("blink_crash_ign", 32'(lives_o), 32'd2);
    cyc(1);
    full_blink("b1");
    cyc(1);
    chk("b1_clear", 32'(outs()), 32'(5'b10000));
    cyc(1);
    chk("b1_load", 32'(outs()), 32'(5'b01000));
    cyc(1);
    chk("b1_run", 32'(outs()), 32'(5'b00100));
    chk("b1_lives", 32'(lives_o), 32'd2);

    // 4a: tick coincident with crash is not counted
    crash_n = 1'b0;
    tick    = 1'b1;
    cyc(1);
    crash_n = 1'b1;
    tick    = 1'b0;
    chk("crash2_lives", 32'(lives_o), 32'd1);
    cyc(1);
    full_blink("b2");
    cyc(1);
    chk("b2_clear", 32'(outs()), 32'(5'b10000));
    cyc(2);

    // 3: third crash leads to game over
    crash_pulse();
    chk("crash3_lives", 32'(lives_o), 32'd0);
    cyc(1);
    full_blink("b3");
    cyc(1);
    chk("gameover_outs", 32'(outs()), 32'(5'b00001));
    chk("gameover_lives", 32'(lives_o), 32'd0);
    crash_n = 1'b0;
    tick    = 1'b1;
    cyc(3);
    crash_n = 1'b1;
    tick    = 1'b0;
    chk("gameover_hold", 32'(outs()), 32'(5'b00001));
    start_round("restart");

    // 5: reset mid-blink
    crash_pulse();
    chk("crash4_lives", 32'(lives_o), 32'd2);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      do_tick();
    end
    chk("pre_rst_blank", 32'(blank_o), 32'd0);
    rst_n   = 1'b0;
    start_n = 1'b0;
    tick    = 1'b1;
    cyc(1);
    rst_n   = 1'b1;
    start_n = 1'b1;
    tick    = 1'b0;
    chk("midrst_outs", 32'(outs()), 32'(5'b00000));
    chk("midrst_lives", 32'(lives_o), 32'd3);
    crash_n = 1'b0;
    cyc(2);
    crash_n = 1'b1;
    chk("idle_crash_lives", 32'(lives_o), 32'd3);
    chk("idle_crash_outs", 32'(outs()), 32'(5'b00000));

    // 4c: start held low for 20 cycles gives one Clear pulse
    clr_cnt = 0;
    start_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (clear_o) clr_cnt++;
    end
    start_n = 1'b1;
    chk("hold_clear_cnt", 32'(clr_cnt), 32'd1);
    chk("hold_run", 32'(outs()), 32'(5'b00100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sc_crashctrl.md
# sc_crashctrl

Game-round controller sitting directly downstream of the crash detector (active-low collision flag from point/background overlap). It owns round sequencing:
- clears and reloads the point and background registers;
- enables shifting while a round runs;
- on collision, freezes play, decrements a lives counter and blinks the display;
- then restarts the round or enters game over.

## Interface
- LIVES_INIT, 3: lives loaded at game start; must satisfy 1 ≤ LIVES_INIT ≤ 2^LIVES_W−1
- LIVES_W, 3: lives counter width
- BLINK_TICKS, 4: Tick_In pulses per blink phase (≥1)
- BLINK_CYCLES, 3: blank/show pairs per crash (≥1)
- SC_CRASHCTRL_CLOCK_50  in  1  system clock; single clock domain
- SC_CRASHCTRL_RESET_InLow  in  1  synchronous, active-low reset
- SC_CRASHCTRL_Crash_InLow  in  1  collision flag from crash detector, 0 = collision
- SC_CRASHCTRL_Start_InLow  in  1  debounced start button, 0 = pressed
- SC_CRASHCTRL_Tick_In  in  1  one-cycle game-step pulse from upstream timer
- SC_CRASHCTRL_Clear_Out  out  1  one-cycle clear of point/background registers
- SC_CRASHCTRL_Load_Out  out  1  one-cycle load of initial patterns
- SC_CRASHCTRL_Run_Out  out  1  shift enable for point/background registers
- SC_CRASHCTRL_Blank_Out  out  1  display blank request
- SC_CRASHCTRL_GameOver_Out  out  1  game-over indicator
- SC_CRASHCTRL_Lives_Out  out  LIVES_W  remaining lives

## Operation
- **Start event:** the cycle where registered previous Start_InLow = 1 and current = 0.
  - Start_prev resets to 1.
  - Start events are acted on only in IDLE and GAMEOVER; ignored elsewhere.
- **FSM states:** IDLE, CLEAR, LOAD, RUN, BLINK, GAMEOVER. All outputs are registered and decoded from the state (Moore).
- **Reset values:** state IDLE, Lives = LIVES_INIT, phase = 0, tick count = 0; Clear, Load, Run, Blank, GameOver all 0.
- **IDLE:** start event → CLEAR, and Lives ← LIVES_INIT.
- **CLEAR:** Clear_Out = 1 for exactly one cycle → LOAD.
- **LOAD:** Load_Out = 1 for exactly one cycle → RUN.
- **RUN:** Run_Out = 1.
  - Crash_InLow is sampled every cycle.
  - Crash_InLow = 0 → BLINK; Lives ← Lives−1, saturating at 0; phase ← 0; tick count ← 0.
- **BLINK:** Run_Out = 0.
  - Blank_Out = 1 on even phases, 0 on odd phases, so the display starts blanked.
  - Each Tick_In increments the tick count. At BLINK_TICKS−1 the tick count wraps to 0 and phase increments.
  - When the last phase (2·BLINK_CYCLES−1) completes: Lives = 0 → GAMEOVER, otherwise → CLEAR.
  - Crash_InLow is ignored.
- **GAMEOVER:** GameOver_Out = 1, Blank_Out = 0, Run_Out = 0. Start event → CLEAR, and Lives ← LIVES_INIT.
- **Tick_In:** ignored outside BLINK.
- **Crash_InLow:** ignored outside RUN.

## Timing
- Start event at edge n → Clear_Out high during cycle n+1, Load_Out at n+2, Run_Out from n+3.
- Crash_InLow low before edge n while in RUN:
  - Run_Out = 0, Blank_Out = 1, Lives decremented, all visible after edge n;
  - exactly one cycle of latency, so at most one shift step can occur after the collision.
- Simultaneous Tick_In and Crash_InLow = 0 in RUN: the crash wins; that tick is not counted toward blink.
- Blink duration: exactly 2·BLINK_CYCLES·BLINK_TICKS Tick_In pulses, then one cycle to reach CLEAR or GAMEOVER.
- Reset is sampled only on the clock edge. Asserting it mid-round returns to IDLE with reset values at the next edge, regardless of the other inputs.
- Start held low does not retrigger; it must return high before a new event can occur.

## Structure
- **Shared package/header:** state encodings (3-bit localparams) and default parameter values, shared with the top level that wires the point/background registers.
- **Sub-module `sc_blinktimer`:** tick counter plus phase counter, with clear and enable inputs.
  - Outputs: phase LSB and a one-cycle done flag.
  - The FSM, lives counter and start edge detector stay in `sc_crashctrl`.

## Test plan
All scenarios use LIVES_INIT=3, BLINK_TICKS=2, BLINK_CYCLES=2.

1. **Reset/start:** release reset, pull Start low at cycle 5 → Clear_Out=1 at 6, Load_Out=1 at 7, Run_Out=1 from 8, Lives=3.
2. **Single crash:** in RUN, drive Crash_InLow=0 for 1 cycle → next cycle Run=0, Blank=1, Lives=2.
   - Blank toggles after every 2 ticks: 1,0,1,0.
   - After the 8th tick: Clear, then Load, then Run=1.
3. **Game over:** three crashes → Lives=0 after the third. After its 8-tick blink → GameOver=1, Run=0, Blank=0. New start event → Lives=3 and the Clear/Load/Run sequence.
4. **Simultaneous events:**
   - Tick and crash on the same cycle in RUN → blink still needs 8 further ticks.
   - Start pulses during RUN and BLINK → no effect.
   - Start held low for 20 cycles in IDLE → exactly one Clear pulse.
5. **Reset mid-BLINK:** assert reset after 3 ticks → next edge: IDLE, Lives=3, all outputs 0. Crash_InLow=0 in IDLE → Lives unchanged.
